// File: rtl/tl_timed_ctrl_if.sv
// rtl/tl_timed_ctrl_if.sv - traffic light controller signal bundle (ped signals only with PED_REQ_EN)
interface tl_timed_ctrl_if;
  logic       Ta;
  logic       Tb;
  logic [1:0] La;
  logic [1:0] Lb;
  logic [2:0] state;
`ifdef PED_REQ_EN
  logic       ped_req;
  logic       ped_walk;

  // master drives the sensors, slave is the controller
  modport master (output Ta, Tb, ped_req, input La, Lb, state, ped_walk);
  modport slave  (input Ta, Tb, ped_req, output La, Lb, state, ped_walk);
`else
  // master drives the sensors, slave is the controller
  modport master (output Ta, Tb, input La, Lb, state);
  modport slave  (input Ta, Tb, output La, Lb, state);
`endif
endinterface

// File: rtl/tl_timed_ctrl.sv
// rtl/tl_timed_ctrl.sv - two-street Moore traffic light controller with dwell timer (walk phase: PED_REQ_EN)
module tl_timed_ctrl #(
  parameter int MIN_GRN  = 8,
  parameter int YEL_CYC  = 4,
  parameter int WALK_CYC = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  tl_timed_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3
`ifdef PED_REQ_EN
    , SW = 3'd4
`endif
  } state_t;

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] RED = 2'b10;

  localparam logic [7:0] GRN_LAST = 8'(MIN_GRN - 1);
  localparam logic [7:0] YEL_LAST = 8'(YEL_CYC - 1);
`ifdef PED_REQ_EN
  localparam logic [7:0] WALK_LAST = 8'(WALK_CYC - 1);
`endif

  // Dwell counts live in an 8-bit timer, so every dwell must fit 1..255.
  if (MIN_GRN < 1 || MIN_GRN > 255 || YEL_CYC < 1 || YEL_CYC > 255 ||
      WALK_CYC < 1 || WALK_CYC > 255) begin : g_bad_param
    $error("tl_timed_ctrl: dwell parameters must lie in 1..255");
  end

  // State is a plain vector so that illegal codes can exist and be recovered from.
  logic [2:0] state_q;
  logic [2:0] nxt;
  logic [7:0] timer_q;
  logic [1:0] la_q;
  logic [1:0] lb_q;
`ifdef PED_REQ_EN
  logic       pend_q;
  logic       walk_q;
`endif

  // Light pair {La, Lb} for a state; anything unknown shows the S0 lights.
  function automatic logic [3:0] lights(input logic [2:0] s);
    case (s)
      S1:      lights = {YEL, RED};
      S2:      lights = {RED, GRN};
      S3:      lights = {RED, YEL};
`ifdef PED_REQ_EN
      SW:      lights = {RED, RED};
`endif
      default: lights = {GRN, RED};
    endcase
  endfunction

  // Next-state decision from the current state, dwell timer and sensors.
  always_comb begin
    nxt = S0;
    case (state_q)
      S0: nxt = (timer_q >= GRN_LAST && !bus.Ta) ? S1 : S0;
      S1: nxt = (timer_q == YEL_LAST) ? S2 : S1;
      S2: nxt = (timer_q >= GRN_LAST && !bus.Tb) ? S3 : S2;
      S3: begin
        if (timer_q == YEL_LAST) begin
`ifdef PED_REQ_EN
          nxt = (pend_q || bus.ped_req) ? SW : S0;
`else
          nxt = S0;
`endif
        end else begin
          nxt = S3;
        end
      end
`ifdef PED_REQ_EN
      SW: nxt = (timer_q == WALK_LAST) ? S0 : SW;
`endif
      default: nxt = S0;
    endcase
  end

  // State, dwell timer, registered lights and walk request bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S0;
      timer_q <= 8'd0;
      la_q    <= GRN;
      lb_q    <= RED;
`ifdef PED_REQ_EN
      pend_q  <= 1'b0;
      walk_q  <= 1'b0;
`endif
    end else begin
      state_q <= nxt;
      if (nxt != state_q) begin
        timer_q <= 8'd0;
      end else if (timer_q != 8'hFF) begin
        timer_q <= timer_q + 8'd1;
      end
      {la_q, lb_q} <= lights(nxt);
`ifdef PED_REQ_EN
      // Entering the walk consumes the request; requests during the walk are dropped.
      if (nxt == SW) begin
        pend_q <= 1'b0;
      end else if (bus.ped_req && state_q != SW) begin
        pend_q <= 1'b1;
      end
      walk_q <= (nxt == SW);
`endif
    end
  end

  assign bus.La    = la_q;
  assign bus.Lb    = lb_q;
  assign bus.state = state_q;
`ifdef PED_REQ_EN
  assign bus.ped_walk = walk_q;
`endif

endmodule
